// File: rtl/led_pattern_gen_if.sv
// Configuration and LED drive bundle for the LED pattern engine.
// master: control logic / switches side; slave: the pattern engine.
interface led_pattern_gen_if #(
    parameter int LED_NUM = 4,
    parameter int DIV_W   = 26
);
    logic               cfg_valid;
    logic [1:0]         cfg_mode;
    logic [DIV_W-1:0]   step_div;
    logic               pause;
    logic [LED_NUM-1:0] led;
    logic [1:0]         mode;
    logic               step_pulse;

    modport master (
        output cfg_valid, cfg_mode, step_div, pause,
        input  led, mode, step_pulse
    );

    modport slave (
        input  cfg_valid, cfg_mode, step_div, pause,
        output led, mode, step_pulse
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern engine: rotate, ping-pong, blink and binary count at a
// programmable step rate.
//
// Ping-pong direction FSM:
//   state      | meaning
//   DIR_LEFT   | lit LED moves towards the MSB on each step
//   DIR_RIGHT  | lit LED moves towards the LSB on each step
module led_pattern_gen #(
    parameter int LED_NUM = 4,
    parameter int DIV_W   = 26
) (
    input  logic              clk,
    input  logic              rst,
    led_pattern_gen_if.slave  bus
);
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [LED_NUM-1:0] LED_ONE = LED_NUM'(1);

    logic [DIV_W-1:0]   div_cnt;
    dir_t               dir;
    dir_t               dir_nxt;
    logic [LED_NUM-1:0] led_q;
    logic [LED_NUM-1:0] led_nxt;
    logic [1:0]         mode_q;
    logic               pulse_q;
    logic               tick;

    // The >= compare lets a live drop of step_div below div_cnt end the step at once.
    assign tick = !bus.pause && (div_cnt >= bus.step_div);

    // Next pattern value for the active mode, applied only on a tick.
    always_comb begin
        led_nxt = led_q;
        dir_nxt = dir;
        case (mode_q)
            2'd0: led_nxt = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
            2'd1: begin
                if (dir == DIR_LEFT) begin
                    if (led_q[LED_NUM-1]) begin
                        dir_nxt = DIR_RIGHT;
                        led_nxt = led_q >> 1;
                    end else begin
                        led_nxt = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        dir_nxt = DIR_LEFT;
                        led_nxt = led_q << 1;
                    end else begin
                        led_nxt = led_q >> 1;
                    end
                end
            end
            2'd2: led_nxt = ~led_q;
            default: led_nxt = led_q + LED_ONE;
        endcase
    end

    // Divider, config load and pattern step; config wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            dir     <= DIR_LEFT;
            led_q   <= LED_ONE;
            mode_q  <= 2'd0;
            pulse_q <= 1'b0;
        end else if (bus.cfg_valid) begin
            div_cnt <= '0;
            dir     <= DIR_LEFT;
            mode_q  <= bus.cfg_mode;
            pulse_q <= 1'b0;
            // Blink and count start dark; the single-LED patterns start at bit 0.
            led_q   <= bus.cfg_mode[1] ? '0 : LED_ONE;
        end else begin
            pulse_q <= tick;
            if (tick) begin
                div_cnt <= '0;
                led_q   <= led_nxt;
                dir     <= dir_nxt;
            end else if (!bus.pause) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    assign bus.led        = led_q;
    assign bus.mode       = mode_q;
    assign bus.step_pulse = pulse_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: step-count based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_led_pattern_gen;
    localparam int N     = 4;
    localparam int DIV_W = 26;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   chk_en;

    led_pattern_gen_if #(.LED_NUM(N), .DIV_W(DIV_W)) bus ();

    led_pattern_gen #(.LED_NUM(N), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pattern is a pure function of mode and steps taken since
    // the last reset/config.
    int     m_mode;
    int     m_k;
    longint m_cnt;
    bit     m_pulse;

    function automatic logic [N-1:0] exp_led(input int md, input int k);
        int p;
        int pos;
        logic [31:0] kv;
        kv = k;
        case (md)
            0: return N'(1) << (k % N);
            1: begin
                p   = k % (2 * N - 2);
                pos = (p < N) ? p : (2 * N - 2 - p);
                return N'(1) << pos;
            end
            2: return (k % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
            default: return kv[N-1:0];
        endcase
    endfunction

    always @(posedge clk) begin
        bit t;
        if (rst) begin
            m_mode = 0; m_k = 0; m_cnt = 0; m_pulse = 0;
        end else if (bus.cfg_valid) begin
            m_mode = int'(bus.cfg_mode); m_k = 0; m_cnt = 0; m_pulse = 0;
        end else begin
            t = !bus.pause && (m_cnt >= longint'(bus.step_div));
            m_pulse = t;
            if (t) begin
                m_k++;
                m_cnt = 0;
            end else if (!bus.pause) begin
                m_cnt++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.led !== exp_led(m_mode, m_k)) begin
                errors++;
                $display("FAIL model_led t=%0t actual=%b expected=%b", $time, bus.led, exp_led(m_mode, m_k));
            end
            checks++;
            if (bus.mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL model_mode t=%0t actual=%0d expected=%0d", $time, bus.mode, m_mode);
            end
            checks++;
            if (bus.step_pulse !== m_pulse) begin
                errors++;
                $display("FAIL model_pulse t=%0t actual=%b expected=%b", $time, bus.step_pulse, m_pulse);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the config edge.
    task automatic do_cfg(input logic [1:0] md, input int div);
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = md;
        bus.step_div  = DIV_W'(div);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    logic [3:0] pp_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] bl_exp [6] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111};
    logic       bl_pul [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 0;
        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_mode  = 2'd0;
        bus.step_div  = DIV_W'(3);
        bus.pause     = 1'b0;

        // Reset held for three edges, then rotate at step_div=3.
        @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        check_lit("rst_led", 32'(bus.led), 32'h1);
        check_lit("rst_mode", 32'(bus.mode), 32'h0);
        check_lit("rst_pulse", 32'(bus.step_pulse), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_lit("rot_hold", 32'(bus.led), 32'h1);
        @(negedge clk);
        check_lit("rot_step1", 32'(bus.led), 32'h2);
        check_lit("rot_pulse1", 32'(bus.step_pulse), 32'h1);
        @(negedge clk);
        check_lit("rot_pulse_low", 32'(bus.step_pulse), 32'h0);
        repeat (3) @(negedge clk);
        check_lit("rot_step2", 32'(bus.led), 32'h4);
        repeat (4) @(negedge clk);
        check_lit("rot_step3", 32'(bus.led), 32'h8);
        repeat (4) @(negedge clk);
        check_lit("rot_wrap", 32'(bus.led), 32'h1);

        // Ping-pong every cycle.
        do_cfg(2'd1, 0);
        check_lit("pp_init", 32'(bus.led), 32'h1);
        check_lit("pp_mode", 32'(bus.mode), 32'h1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_lit($sformatf("pp_step%0d", i), 32'(bus.led), 32'(pp_exp[i]));
            check_lit($sformatf("pp_pulse%0d", i), 32'(bus.step_pulse), 32'h1);
        end

        // Blink, toggling every two cycles.
        do_cfg(2'd2, 1);
        check_lit("bl_init", 32'(bus.led), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_lit($sformatf("bl_led%0d", i), 32'(bus.led), 32'(bl_exp[i]));
            check_lit($sformatf("bl_pulse%0d", i), 32'(bus.step_pulse), 32'(bl_pul[i]));
        end

        // Binary count with wrap at the 16th step.
        do_cfg(2'd3, 0);
        check_lit("cnt_init", 32'(bus.led), 32'h0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check_lit($sformatf("cnt_%0d", i), 32'(bus.led), 32'(i % 16));
        end

        // Pause for 20 cycles at div_cnt=5 with step_div=9.
        do_cfg(2'd0, 9);
        repeat (5) @(negedge clk);
        bus.pause = 1'b1;
        repeat (20) @(negedge clk);
        check_lit("pause_led", 32'(bus.led), 32'h1);
        check_lit("pause_pulse", 32'(bus.step_pulse), 32'h0);
        bus.pause = 1'b0;
        repeat (4) @(negedge clk);
        check_lit("unpause_hold", 32'(bus.led), 32'h1);
        @(negedge clk);
        check_lit("unpause_step", 32'(bus.led), 32'h2);
        check_lit("unpause_pulse", 32'(bus.step_pulse), 32'h1);

        // Config issued while paused: pattern frozen at its init value.
        bus.pause = 1'b1;
        do_cfg(2'd3, 0);
        repeat (3) @(negedge clk);
        check_lit("pcfg_led", 32'(bus.led), 32'h0);
        check_lit("pcfg_mode", 32'(bus.mode), 32'h3);
        bus.pause = 1'b0;
        @(negedge clk);
        check_lit("pcfg_release", 32'(bus.led), 32'h1);

        // Config coincident with a tick at led=0100.
        do_cfg(2'd0, 0);
        repeat (2) @(negedge clk);
        check_lit("coin_pre", 32'(bus.led), 32'h4);
        do_cfg(2'd3, 0);
        check_lit("coin_led", 32'(bus.led), 32'h0);
        check_lit("coin_mode", 32'(bus.mode), 32'h3);
        check_lit("coin_pulse", 32'(bus.step_pulse), 32'h0);

        // Lowering step_div from 20 to 2 at div_cnt=10.
        do_cfg(2'd0, 20);
        repeat (10) @(negedge clk);
        check_lit("lower_pre", 32'(bus.led), 32'h1);
        bus.step_div = DIV_W'(2);
        @(negedge clk);
        check_lit("lower_led", 32'(bus.led), 32'h2);
        check_lit("lower_pulse", 32'(bus.step_pulse), 32'h1);

        // Reset during ping-pong heading right at led=0100.
        do_cfg(2'd1, 0);
        repeat (4) @(negedge clk);
        check_lit("mid_pre", 32'(bus.led), 32'h4);
        rst = 1'b1;
        bus.step_div = DIV_W'(3);
        @(negedge clk);
        rst = 1'b0;
        check_lit("mid_led", 32'(bus.led), 32'h1);
        check_lit("mid_mode", 32'(bus.mode), 32'h0);
        check_lit("mid_pulse", 32'(bus.step_pulse), 32'h0);
        repeat (3) @(negedge clk);
        check_lit("mid_hold", 32'(bus.led), 32'h1);
        @(negedge clk);
        check_lit("mid_resume", 32'(bus.led), 32'h2);

        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine, the successor to the fixed 4-LED test driver. It drives LED_NUM outputs with a programmable step rate and four run-time selectable patterns. Patterns: rotate, ping-pong, blink, binary count. It sits directly behind the board LED pins and is configured by a single-cycle config strobe from the control logic or the top-level switches.

Parameters:
LED_NUM, 4, number of LED outputs; legal range 2..32.
DIV_W, 26, width of the step divider counter and the step_div input.

Ports:
clk  input  1  system clock, 50 MHz on the board.
rst  input  1  synchronous reset, active-high.
cfg_valid  input  1  single-cycle strobe; loads cfg_mode and restarts the pattern.
cfg_mode  input  2  pattern select: 0 rotate-left, 1 ping-pong, 2 blink, 3 binary count.
step_div  input  DIV_W  step period minus 1, in clk cycles; read live.
pause  input  1  freeze the divider and the pattern while high.
led  output  LED_NUM  LED drive, active-high.
mode  output  2  currently active pattern.
step_pulse  output  1  one-cycle pulse in the first cycle led shows a new step value.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - led = 1 (LSB set, others 0); mode = 0; step_pulse = 0.
  - Internal: div_cnt = 0, dir = left.
  - rst overrides every other input, including a reset asserted mid-step.
- Divider:
  - tick = !pause && (div_cnt >= step_div).
  - On tick, div_cnt <= 0; otherwise, if !pause, div_cnt <= div_cnt + 1.
  - step_div = 0 gives a tick every cycle. Steady-state step period is step_div+1 cycles.
  - The >= compare means that lowering step_div below the current div_cnt ticks on the next cycle.
- Pause: div_cnt, led and dir hold while pause is high. On release, counting resumes from the held div_cnt.
- Config (cfg_valid high) has priority over tick in the same cycle. It sets:
  - mode <= cfg_mode; div_cnt <= 0; dir <= left; step_pulse <= 0.
  - led <= init pattern: modes 0 and 1 → 1; modes 2 and 3 → 0.
  - cfg_valid is honoured even while pause is high; the pattern stays frozen at its init value.
- Step update on tick (registered; led changes in the cycle after tick, and step_pulse is high in that same cycle):
  - mode 0: led <= {led[LED_NUM-2:0], led[LED_NUM-1]} (rotate left, wraps MSB→LSB).
  - mode 1, dir left:
    - if led[LED_NUM-1]: dir <= right, led <= led >> 1;
    - else led <= led << 1.
  - mode 1, dir right:
    - if led[0]: dir <= left, led <= led << 1;
    - else led <= led >> 1.
  - Mode 1 period is 2*LED_NUM-2 steps; end LEDs are lit for one step each.
  - mode 2: led <= ~led (all-off ↔ all-on).
  - mode 3: led <= led + 1, modulo 2^LED_NUM; all-ones wraps to 0.
- step_pulse is high only in cycles following a tick. It is never high for two consecutive cycles unless step_div = 0.
- In modes 0 and 1, exactly one LED is lit at every cycle after reset or config.

Test Plan:
- Reset / rotate: rst high 3 cycles, step_div=3, LED_NUM=4 → led=0001 and mode=0 during and after reset. led steps 0010, 0100, 1000, 0001 every 4 cycles, with step_pulse high 1 cycle at each change.
- Ping-pong: cfg_valid with cfg_mode=1, step_div=0 → led=0001 then per cycle 0010, 0100, 1000, 0100, 0010, 0001, 0010; period 6.
- Blink and count wrap:
  - mode 2, step_div=1 → led 0000, 1111, 0000, toggling every 2 cycles.
  - mode 3, step_div=0 → 0000..1111, then 0000 on the 16th step.
- Pause: mode 0, step_div=9, pause high for 20 cycles at div_cnt=5 → led and step_pulse frozen. After release, the next change occurs 5 cycles later.
- Simultaneous events:
  - cfg_valid (mode 3) coincident with a tick in mode 0 at led=0100 → next led=0000, mode=3, step_pulse=0.
  - Lowering step_div from 20 to 2 at div_cnt=10 → tick on the next cycle.
- Reset mid-operation: rst pulsed for 1 cycle during mode 1, dir right, led=0100 → next cycle led=0001, mode=0, dir left. Rotate resumes after step_div+1 cycles.
